// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine; a $4014 write halts the CPU and copies page $XX00-$XXFF into PPU OAM.
// Define OAMDMA_ALIGN_EN to add the odd-cycle ALIGN stall (514-cycle transfers instead of 513).
module oam_dma #(
    parameter logic [15:0] REG_DMA     = 16'h4014,
    parameter logic [15:0] REG_OAMADDR = 16'h2003
) (
    input  logic        clock25,
    input  logic        reset,
    input  logic        ce_cpu,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_w,
    output logic        busy,
    output logic [15:0] dma_a,
    input  logic [7:0]  dma_i,
    output logic        dma_rd,
    output logic [7:0]  oam_a,
    output logic [7:0]  oam_d,
    output logic        oam_we
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    state_t     r_state, w_next;
    logic [7:0] r_page, r_cnt, r_oam_ptr;
    logic       w_snoop, w_dma_wr, w_ptr_wr, w_align;

    // Register snooping is only live in IDLE so a glitch write while halted cannot retrigger
    assign w_snoop  = ce_cpu && cpu_w && (r_state == IDLE);
    assign w_dma_wr = w_snoop && (cpu_a == REG_DMA);
    assign w_ptr_wr = w_snoop && (cpu_a == REG_OAMADDR);

`ifdef OAMDMA_ALIGN_EN
    logic r_odd, r_start_odd;
    always_ff @(posedge clock25) begin
        if (reset) begin
            r_odd       <= 1'b0;
            r_start_odd <= 1'b0;
        end else if (ce_cpu) begin
            r_odd <= ~r_odd;
            if (w_dma_wr) r_start_odd <= r_odd;
        end
    end
    assign w_align = r_start_odd;
`else
    assign w_align = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_dma_wr ? HALT : IDLE;
            HALT:    w_next = w_align ? ALIGN : READ;
            ALIGN:   w_next = READ;
            READ:    w_next = WRITE;
            WRITE:   w_next = (r_cnt == 8'hFF) ? IDLE : READ;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock25) begin
        if (reset) r_state <= IDLE;
        else if (ce_cpu) r_state <= w_next;
    end

    always_ff @(posedge clock25) begin
        if (reset) begin
            r_page    <= 8'h00;
            r_cnt     <= 8'h00;
            r_oam_ptr <= 8'h00;
        end else if (ce_cpu) begin
            if (w_ptr_wr) r_oam_ptr <= cpu_d;
            if (w_dma_wr) begin
                r_page <= cpu_d;
                r_cnt  <= 8'h00;
            end
            if (r_state == WRITE) begin
                r_oam_ptr <= r_oam_ptr + 8'h01;
                r_cnt     <= r_cnt + 8'h01;
            end
        end
    end

    // Read data arrives one CPU cycle after the READ address, i.e. during WRITE
    assign busy   = (r_state != IDLE);
    assign dma_rd = (r_state == READ);
    assign dma_a  = {r_page, r_cnt};
    assign oam_a  = r_oam_ptr;
    assign oam_d  = (r_state == WRITE) ? dma_i : 8'h00;
    assign oam_we = (r_state == WRITE) && ce_cpu;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed self-checking bench for oam_dma with a behavioural RAM and OAM.
module tb_oam_dma;
    logic        clock25 = 1'b0, reset = 1'b1, ce_en = 1'b1, ce_phase = 1'b0;
    logic        ce_cpu, cpu_w = 1'b0, busy, dma_rd, oam_we;
    logic [15:0] cpu_a = 16'h0000, dma_a;
    logic [7:0]  cpu_d = 8'h00, dma_i = 8'h00, oam_a, oam_d;
    logic        par = 1'b0;
    logic [7:0]  ram [0:65535];
    logic [7:0]  oam [0:255];
    int          we_total = 0, busy_total = 0;
    int          n_checks = 0, n_fail = 0;

    oam_dma dut (
        .clock25(clock25), .reset(reset), .ce_cpu(ce_cpu), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_w(cpu_w), .busy(busy), .dma_a(dma_a), .dma_i(dma_i), .dma_rd(dma_rd),
        .oam_a(oam_a), .oam_d(oam_d), .oam_we(oam_we)
    );

    always #5 clock25 = ~clock25;
    assign ce_cpu = ce_en & ce_phase;

    always @(posedge clock25) begin
        ce_phase <= ~ce_phase;
        par <= reset ? 1'b0 : (ce_cpu ? ~par : par);
        if (ce_cpu) dma_i <= ram[dma_a];
        if (oam_we) begin
            oam[oam_a] <= oam_d;
            we_total <= we_total + 1;
        end
        if (ce_cpu && busy) busy_total <= busy_total + 1;
    end

    function automatic logic [7:0] pat(input logic [7:0] p, input logic [7:0] i);
        return i ^ 8'h5A ^ (p ^ 8'h02);
    endfunction

    `ifdef OAMDMA_ALIGN_EN
    localparam int ODD_LEN = 514;
    `else
    localparam int ODD_LEN = 513;
    `endif

    task automatic tick();
        @(posedge clock25);
        #1;
    endtask

    // want_par: 0 even, 1 odd, -1 any
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int want_par);
        int k = 0;
        while (!(ce_cpu && (want_par < 0 || int'(par) == want_par)) && k < 20) begin
            tick();
            k++;
        end
        cpu_a = a; cpu_d = d; cpu_w = 1'b1;
        tick();
        cpu_w = 1'b0; cpu_a = 16'h0000; cpu_d = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 3000) begin
            tick();
            k++;
        end
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL %s: timeout, busy=%b required 0", name, busy);
        end
    endtask

    task automatic wait_writes(input int base, input int n);
        int k = 0;
        while (we_total - base < n && k < 3000) begin
            tick();
            k++;
        end
        n_checks++;
        if (we_total - base < n) begin
            n_fail++;
            $display("FAIL wait_writes: got %0d required %0d", we_total - base, n);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_oam(input string name, input logic [7:0] p, input logic [7:0] start);
        int bad = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ix = start + 8'(i);
            n_checks++;
            if (oam[ix] !== pat(p, 8'(i))) begin
                n_fail++;
                if (bad++ < 4) $display("FAIL %s: oam[%02h]=%02h required %02h", name, ix, oam[ix], pat(p, 8'(i)));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        n_checks++;
        if ({busy, dma_rd, oam_we, dma_a, oam_a, oam_d} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b dma_rd=%b oam_we=%b dma_a=%h oam_a=%h oam_d=%h required all 0",
                     busy, dma_rd, oam_we, dma_a, oam_a, oam_d);
        end
    endtask

    task automatic run_full(input string name, input logic [7:0] p, input logic [7:0] start,
                            input int want_par, input int exp_len);
        int b0, w0;
        cpu_write(16'h2003, start, -1);
        b0 = busy_total; w0 = we_total;
        cpu_write(16'h4014, p, want_par);
        wait_idle(name);
        tick();
        check_int({name, "_busy_len"}, busy_total - b0, exp_len);
        check_int({name, "_writes"}, we_total - w0, 256);
        check_oam(name, p, start);
        check_int({name, "_ptr_end"}, int'(oam_a), int'(start));
    endtask

    task automatic test_even();
        run_full("even", 8'h02, 8'h00, 0, 513);
    endtask

    task automatic test_odd();
        run_full("odd", 8'h02, 8'h00, 1, ODD_LEN);
    endtask

    task automatic test_ptr_wrap();
        run_full("wrap", 8'h03, 8'hF0, -1, -1 == 0 ? 0 : (par ? 513 : 513));
    endtask

    task automatic test_retrigger();
        int w0, b0;
        cpu_write(16'h2003, 8'h00, -1);
        w0 = we_total; b0 = busy_total;
        cpu_write(16'h4014, 8'h04, 0);
        wait_writes(w0, 100);
        cpu_write(16'h4014, 8'h05, -1);
        cpu_write(16'h2003, 8'h33, -1);
        wait_idle("retrig");
        tick();
        check_int("retrig_writes", we_total - w0, 256);
        check_int("retrig_busy_len", busy_total - b0, 513);
        check_oam("retrig", 8'h04, 8'h00);
        check_int("retrig_ptr_end", int'(oam_a), 0);
    endtask

    task automatic test_mid_reset();
        int w0;
        cpu_write(16'h2003, 8'h00, -1);
        w0 = we_total;
        cpu_write(16'h4014, 8'h02, -1);
        wait_writes(w0, 40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({busy, dma_rd, oam_we, oam_a, dma_a} !== 27'd0) begin
            n_fail++;
            $display("FAIL midreset: busy=%b dma_rd=%b oam_we=%b oam_a=%h dma_a=%h required all 0",
                     busy, dma_rd, oam_we, oam_a, dma_a);
        end
        repeat (30) tick();
        check_int("midreset_no_writes", we_total - w0, 40);
        run_full("after_reset", 8'h03, 8'h00, 0, 513);
    endtask

    task automatic test_ce_hold();
        int w0, k = 0, bad = 0;
        logic [15:0] a0;
        cpu_write(16'h2003, 8'h00, -1);
        w0 = we_total;
        cpu_write(16'h4014, 8'h04, -1);
        while (!(dma_rd && we_total - w0 >= 10) && k < 3000) begin
            tick();
            k++;
        end
        ce_en = 1'b0;
        a0 = dma_a;
        check_int("hold_in_read", int'(dma_rd), 1);
        check_int("hold_addr_start", int'(a0), int'({8'h04, 8'(we_total - w0)}));
        repeat (50) begin
            tick();
            if (dma_a !== a0 || oam_we !== 1'b0 || dma_rd !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d unstable cycles required 0", bad);
        end
        check_int("hold_no_writes", we_total - w0, int'(a0[7:0]));
        ce_en = 1'b1;
        wait_idle("hold");
        tick();
        check_int("hold_writes", we_total - w0, 256);
        check_oam("hold", 8'h04, 8'h00);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = pat(8'(a >> 8), 8'(a));
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
        test_reset();
        test_even();
        test_odd();
        run_full("wrap", 8'h03, 8'hF0, 0, 513);
        test_retrigger();
        test_mid_reset();
        test_ce_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
